rr_arbitration_tree: RTL and testbench

- Parametrised, registered, two-level round-robin arbitration tree. Grants exactly one of GROUPS*GROUP_SIZE requesters per cycle.
- Level 1: one round-robin arbiter per group. Level 2: a round-robin base arbiter across groups.
- Optional grant hold (lock) with a bounded hold length.
- Used in front of shared issue/writeback resources, where fairness across all requesters is required.

---
 rtl/arb_pkg.sv | 32 +++
 rtl/rr_arbiter.sv | 67 ++++++
 rtl/rr_arbitration_tree.sv | 142 ++++++++++++++
 tb/tb_rr_arbitration_tree.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pkg
//  Description : Shared defaults, action encoding and one-hot helper for the
//                round-robin arbitration tree.
//  Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

  localparam int DEF_GROUPS     = 4;
  localparam int DEF_GROUP_SIZE = 4;

  // Widest grant vector the index helper accepts; callers zero-extend into it.
  localparam int ONEHOT_MAX_W   = 256;

  typedef enum logic [1:0] {
    ACT_IDLE = 2'd0,
    ACT_NEW  = 2'd1,
    ACT_HOLD = 2'd2
  } arb_action_e;

  function automatic int unsigned onehot_to_index(input logic [ONEHOT_MAX_W-1:0] vec);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < ONEHOT_MAX_W; i++) begin
      if (vec[i]) idx = idx | unsigned'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : N-way round-robin pick starting at an internal pointer, with
//                pointer advance past the winner when update_IN is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clock_IN,
  input  logic         resetn_IN,
  input  logic [N-1:0] req_IN,
  input  logic         update_IN,
  output logic [N-1:0] grant_OUT,
  output logic         any_req_OUT
);

  localparam int            PW    = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW:0]   N_EXT = (PW+1)'(N);
  localparam logic [PW-1:0] LAST  = PW'(N - 1);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] win;
  logic [PW-1:0] cand;
  logic [PW:0]   sum;
  logic          found;

  // Compare-to-limit wrap keeps non-power-of-two widths correct.
  always_comb begin
    grant_OUT = '0;
    found     = 1'b0;
    win       = '0;
    sum       = '0;
    cand      = '0;
    for (int off = 0; off < N; off++) begin
      sum = {1'b0, ptr_q} + (PW+1)'(off);
      if (sum >= N_EXT) sum = sum - N_EXT;
      cand = sum[PW-1:0];
      if (!found && req_IN[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    if (found) grant_OUT[win] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (update_IN && found) begin
      ptr_d = (win == LAST) ? '0 : win + PW'(1);
    end
  end

  assign any_req_OUT = |req_IN;

  always_ff @(posedge clock_IN) begin
    if (!resetn_IN) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rr_arbitration_tree.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbitration_tree
//  Description : Registered two-level round-robin arbiter (per-group + base)
//                with optional bounded grant hold.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbitration_tree
  import arb_pkg::*;
#(
  parameter int GROUPS     = DEF_GROUPS,
  parameter int GROUP_SIZE = DEF_GROUP_SIZE,
  parameter int HOLD_MODE  = 0,
  parameter int MAX_HOLD   = 0,
  localparam int NUM_REQ   = GROUPS * GROUP_SIZE,
  localparam int IDX_W     = $clog2(NUM_REQ)
) (
  input  logic               clock_IN,
  input  logic               resetn_IN,
  input  logic [NUM_REQ-1:0] requests_IN,
  output logic [NUM_REQ-1:0] grants_OUT,
  output logic               grant_valid_OUT,
  output logic [IDX_W-1:0]   grant_index_OUT
);

  localparam int               HOLD_SAT   = (MAX_HOLD > 0) ? MAX_HOLD : 1;
  localparam int               CNT_W      = $clog2(HOLD_SAT + 1);
  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(HOLD_SAT);

  logic [NUM_REQ-1:0] grants_q, grants_d;
  logic               valid_q, valid_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;

  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] new_grant;
  logic [IDX_W-1:0]   new_index;
  logic [GROUPS-1:0]  group_req;
  logic [GROUPS-1:0]  base_grant;
  logic [GROUPS-1:0][GROUP_SIZE-1:0] grp_grant;
  logic               holder_req;
  logic               limit_hit;
  logic               others_req;
  arb_action_e        action;

  assign holder_req = valid_q && (|(requests_IN & grants_q));
  assign limit_hit  = (MAX_HOLD > 0) && (hold_cnt_q >= HOLD_LIMIT);
  assign others_req = |(requests_IN & ~grants_q);

  // An expired holder is masked only if someone else can take the grant.
  always_comb begin
    arb_req = requests_IN;
    if ((HOLD_MODE != 0) && (MAX_HOLD > 0) && holder_req && limit_hit && others_req) begin
      arb_req = requests_IN & ~grants_q;
    end
  end

  always_comb begin
    if ((HOLD_MODE != 0) && holder_req && !limit_hit) begin
      action = ACT_HOLD;
    end else if (|arb_req) begin
      action = ACT_NEW;
    end else begin
      action = ACT_IDLE;
    end
  end

  rr_arbiter #(
    .N (GROUPS)
  ) u_base_arb (
    .clock_IN    (clock_IN),
    .resetn_IN   (resetn_IN),
    .req_IN      (group_req),
    .update_IN   (action == ACT_NEW),
    .grant_OUT   (base_grant),
    .any_req_OUT ()
  );

  for (genvar g = 0; g < GROUPS; g++) begin : g_group
    rr_arbiter #(
      .N (GROUP_SIZE)
    ) u_group_arb (
      .clock_IN    (clock_IN),
      .resetn_IN   (resetn_IN),
      .req_IN      (arb_req[g*GROUP_SIZE +: GROUP_SIZE]),
      .update_IN   ((action == ACT_NEW) && base_grant[g]),
      .grant_OUT   (grp_grant[g]),
      .any_req_OUT (group_req[g])
    );

    assign new_grant[g*GROUP_SIZE +: GROUP_SIZE] = base_grant[g] ? grp_grant[g] : '0;
  end

  assign new_index = IDX_W'(onehot_to_index(ONEHOT_MAX_W'(new_grant)));

  always_comb begin
    grants_d   = '0;
    valid_d    = 1'b0;
    index_d    = '0;
    hold_cnt_d = '0;
    unique case (action)
      ACT_HOLD: begin
        grants_d   = grants_q;
        valid_d    = 1'b1;
        index_d    = index_q;
        hold_cnt_d = (hold_cnt_q == HOLD_LIMIT) ? hold_cnt_q : hold_cnt_q + CNT_W'(1);
      end
      ACT_NEW: begin
        grants_d   = new_grant;
        valid_d    = 1'b1;
        index_d    = new_index;
        hold_cnt_d = CNT_W'(1);
      end
      default: begin
        grants_d   = '0;
        valid_d    = 1'b0;
        index_d    = '0;
        hold_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock_IN) begin
    if (!resetn_IN) begin
      grants_q   <= '0;
      valid_q    <= 1'b0;
      index_q    <= '0;
      hold_cnt_q <= '0;
    end else begin
      grants_q   <= grants_d;
      valid_q    <= valid_d;
      index_q    <= index_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign grants_OUT      = grants_q;
  assign grant_valid_OUT = valid_q;
  assign grant_index_OUT = index_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbitration_tree.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arbitration_tree
//  Description : Scoreboard bench for three arbiter configurations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbitration_tree;

  logic        clk;
  logic        rstn;
  logic [15:0] req;
  logic [15:0] gr  [3];
  logic        vld [3];
  logic [3:0]  idx [3];

  int vectors;
  int miscompares;

  typedef struct {
    int          sel;
    int          step;
    logic        valid;
    logic [3:0]  idx;
    logic [15:0] grants;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dut0: re-arbitrate every cycle; dut1: unlimited hold; dut2: hold bounded to 4.
  rr_arbitration_tree #(.GROUPS(4), .GROUP_SIZE(4), .HOLD_MODE(0), .MAX_HOLD(0)) u_dut0 (
    .clock_IN(clk), .resetn_IN(rstn), .requests_IN(req),
    .grants_OUT(gr[0]), .grant_valid_OUT(vld[0]), .grant_index_OUT(idx[0]));
  rr_arbitration_tree #(.GROUPS(4), .GROUP_SIZE(4), .HOLD_MODE(1), .MAX_HOLD(0)) u_dut1 (
    .clock_IN(clk), .resetn_IN(rstn), .requests_IN(req),
    .grants_OUT(gr[1]), .grant_valid_OUT(vld[1]), .grant_index_OUT(idx[1]));
  rr_arbitration_tree #(.GROUPS(4), .GROUP_SIZE(4), .HOLD_MODE(1), .MAX_HOLD(4)) u_dut2 (
    .clock_IN(clk), .resetn_IN(rstn), .requests_IN(req),
    .grants_OUT(gr[2]), .grant_valid_OUT(vld[2]), .grant_index_OUT(idx[2]));

  // Drive one cycle of stimulus, queue what the selected DUT must show, then
  // advance to just after the sampling edge.
  task automatic apply(input logic [15:0] r, input logic rn, input int sel,
                       input int step, input logic ev, input logic [3:0] ei);
    exp_t        x;
    logic [15:0] one;
    one      = 16'h0001;
    @(negedge clk);
    req      = r;
    rstn     = rn;
    x.sel    = sel;
    x.step   = step;
    x.valid  = ev;
    x.idx    = ev ? ei : 4'd0;
    x.grants = ev ? (one << ei) : 16'h0000;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      apply(16'hFFFF, (k == 2), 0, k, (k == 2), 4'd0);
      e = sb.pop_front();
      vectors++;
      if (vld[e.sel] !== e.valid || idx[e.sel] !== e.idx || gr[e.sel] !== e.grants) begin
        miscompares++;
        $display("FAIL reset step %0d: got valid=%b idx=%0d grants=%h, need valid=%b idx=%0d grants=%h",
                 e.step, vld[e.sel], idx[e.sel], gr[e.sel], e.valid, e.idx, e.grants);
      end
    end
  endtask

  task automatic test_fairness();
    apply(16'hFFFF, 1'b0, 0, -1, 1'b0, 4'd0);
    void'(sb.pop_front());
    for (int k = 0; k < 32; k++) begin
      apply(16'hFFFF, 1'b1, 0, k, 1'b1, 4'((k % 4) * 4 + (k / 4) % 4));
      e = sb.pop_front();
      vectors++;
      if (vld[e.sel] !== e.valid || idx[e.sel] !== e.idx || gr[e.sel] !== e.grants) begin
        miscompares++;
        $display("FAIL fairness step %0d: got valid=%b idx=%0d grants=%h, need valid=%b idx=%0d grants=%h",
                 e.step, vld[e.sel], idx[e.sel], gr[e.sel], e.valid, e.idx, e.grants);
      end
    end
  endtask

  task automatic test_sparse();
    apply(16'h0000, 1'b0, 0, -1, 1'b0, 4'd0);
    void'(sb.pop_front());
    for (int k = 0; k < 11; k++) begin
      if (k < 4)       apply(16'h0400, 1'b1, 0, k, 1'b1, 4'd10);
      else if (k == 4) apply(16'h0000, 1'b1, 0, k, 1'b0, 4'd0);
      else             apply(16'h0401, 1'b1, 0, k, 1'b1, (k % 2 == 1) ? 4'd0 : 4'd10);
      e = sb.pop_front();
      vectors++;
      if (vld[e.sel] !== e.valid || idx[e.sel] !== e.idx || gr[e.sel] !== e.grants) begin
        miscompares++;
        $display("FAIL sparse step %0d: got valid=%b idx=%0d grants=%h, need valid=%b idx=%0d grants=%h",
                 e.step, vld[e.sel], idx[e.sel], gr[e.sel], e.valid, e.idx, e.grants);
      end
    end
  endtask

  task automatic test_hold();
    apply(16'h0003, 1'b0, 1, -1, 1'b0, 4'd0);
    void'(sb.pop_front());
    for (int k = 0; k < 12; k++) begin
      if (k < 9) apply(16'h0003, 1'b1, 1, k, 1'b1, 4'd0);
      else       apply(16'h0002, 1'b1, 1, k, 1'b1, 4'd1);
      e = sb.pop_front();
      vectors++;
      if (vld[e.sel] !== e.valid || idx[e.sel] !== e.idx || gr[e.sel] !== e.grants) begin
        miscompares++;
        $display("FAIL hold step %0d: got valid=%b idx=%0d grants=%h, need valid=%b idx=%0d grants=%h",
                 e.step, vld[e.sel], idx[e.sel], gr[e.sel], e.valid, e.idx, e.grants);
      end
    end
  endtask

  task automatic test_bounded_hold();
    apply(16'h0101, 1'b0, 2, -1, 1'b0, 4'd0);
    void'(sb.pop_front());
    for (int k = 0; k < 26; k++) begin
      if (k < 16) apply(16'h0101, 1'b1, 2, k, 1'b1, ((k / 4) % 2 == 1) ? 4'd8 : 4'd0);
      else        apply(16'h0001, 1'b1, 2, k, 1'b1, 4'd0);
      e = sb.pop_front();
      vectors++;
      if (vld[e.sel] !== e.valid || idx[e.sel] !== e.idx || gr[e.sel] !== e.grants) begin
        miscompares++;
        $display("FAIL bounded_hold step %0d: got valid=%b idx=%0d grants=%h, need valid=%b idx=%0d grants=%h",
                 e.step, vld[e.sel], idx[e.sel], gr[e.sel], e.valid, e.idx, e.grants);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    apply(16'h0101, 1'b0, 2, -1, 1'b0, 4'd0);
    void'(sb.pop_front());
    // Six granted cycles (0 x4, 8 x2), a one-cycle reset, then a fresh 0 x4 / 8 x4.
    for (int k = 0; k < 15; k++) begin
      if (k < 6)       apply(16'h0101, 1'b1, 2, k, 1'b1, (k < 4) ? 4'd0 : 4'd8);
      else if (k == 6) apply(16'h0101, 1'b0, 2, k, 1'b0, 4'd0);
      else             apply(16'h0101, 1'b1, 2, k, 1'b1, (k < 11) ? 4'd0 : 4'd8);
      e = sb.pop_front();
      vectors++;
      if (vld[e.sel] !== e.valid || idx[e.sel] !== e.idx || gr[e.sel] !== e.grants) begin
        miscompares++;
        $display("FAIL reset_mid_hold step %0d: got valid=%b idx=%0d grants=%h, need valid=%b idx=%0d grants=%h",
                 e.step, vld[e.sel], idx[e.sel], gr[e.sel], e.valid, e.idx, e.grants);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rstn        = 1'b0;
    req         = 16'h0000;
    test_reset();
    test_fairness();
    test_sparse();
    test_hold();
    test_bounded_hold();
    test_reset_mid_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
